memory_pipe: RTL and testbench
==============================

# memory_pipe

Parametrised single-clock, one-write/one-read memory. It succeeds the basic `memory` block and adds:
- per-lane write enables;
- selectable read latency;
- a selectable read/write collision mode;
- out-of-range address detection;
- a self-clearing reset sweep.

It is the storage primitive for buffers and lookup tables in the datapath. Producers write through the `addr_w` port, and consumers read through the `addr_r` port with a `data_valid` qualifier.

## Interface
Parameters:
- `MEM_SIZE`, 6, number of words; any value ≥ 2, not required to be a power of two.
- `DATA_W`, 10, word width in bits.
- `LANE_W`, 5, write-enable lane width. `DATA_W % LANE_W == 0`. `LANES = DATA_W/LANE_W`.
- `RD_LAT`, 1, read latency in cycles; legal values are 1 and 2.
- `RW_MODE`, 0, behaviour on a same-address read and write: 0 = read-first (old data), 1 = write-first (new merged data).
- `INIT_VAL`, 0, `DATA_W`-bit value written to every word by the reset sweep.
- Derived: `ADDR_SIZE = $clog2(MEM_SIZE)`.

Ports:
- `clk`  in  1  single clock; all logic acts on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `write_flag`  in  1  write request.
- `byte_en`  in  `LANES`  lane enables; bit i covers `data_in[i*LANE_W +: LANE_W]`.
- `data_in`  in  `DATA_W`  write data.
- `addr_w`  in  `ADDR_SIZE`  write address.
- `read_flag`  in  1  read request.
- `addr_r`  in  `ADDR_SIZE`  read address.
- `data_out`  out  `DATA_W`  read data; holds its last value between reads.
- `data_valid`  out  1  one-cycle pulse that qualifies `data_out`.
- `err_flag`  out  1  one-cycle pulse reporting an out-of-range access, aligned with `data_valid` for reads.
- `busy`  out  1  high while the clear sweep runs; requests are ignored while it is high.

## Operation
- **States:** `CLEAR` and `READY`.
- **Reset** (`rst` sampled high): state <= `CLEAR`, `clr_addr` <= 0, `busy` <= 1, `data_out` <= 0, `data_valid` <= 0, `err_flag` <= 0. The read pipeline is flushed.
- **`CLEAR`:**
  - Each cycle writes `INIT_VAL` to `clr_addr`, then increments it.
  - On the cycle that writes `MEM_SIZE-1`, the next state is `READY` and `busy` <= 0.
  - While `rst` stays high, the sweep holds at address 0.
  - Reset asserted mid-sweep restarts the sweep from 0.
- **`READY`, write:**
  - Occurs when `write_flag` = 1 and `addr_w < MEM_SIZE`.
  - Lane i is updated only where `byte_en[i]` = 1. `byte_en` = 0 performs no write.
  - `addr_w >= MEM_SIZE`: the write is dropped and `err_flag` pulses 1 cycle later (no `data_valid`).
- **`READY`, read:**
  - Occurs when `read_flag` = 1.
  - The word is captured at the edge and presented after `RD_LAT` cycles with a `data_valid` pulse.
  - `addr_r >= MEM_SIZE`: `data_out` = 0 with `data_valid` = 1 and `err_flag` = 1.
  - If both a read error and a write error occur in one cycle, `err_flag` shows one combined pulse.
- **Collision** (`addr_r == addr_w`, both flags high, in range):
  - `RW_MODE` = 0: the read returns the pre-write word.
  - `RW_MODE` = 1: the read returns the word with the enabled lanes replaced by `data_in`.
- **In-flight reads:** with `RD_LAT` = 2, a read already captured is unaffected by writes in later cycles.
- **Reads and writes while `busy`:** ignored. They produce no `data_valid` and no `err_flag`.

## Timing
- Read latency is exactly `RD_LAT` edges after the request edge. `RD_LAT` = 1 uses a registered output. `RD_LAT` = 2 adds one output register, with the valid bit pipelined alongside the data.
- Back-to-back reads sustain 1 word per cycle.
- A write is visible to a read issued on the following cycle.
- `busy` is high for `MEM_SIZE` cycles after the first low `rst` edge. The first accepted request arrives on the edge where `busy` is sampled 0.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Package `memory_pkg` holds:
  - the state enum (`CLEAR`, `READY`);
  - the `RW_MODE` constants (`RD_FIRST` = 0, `WR_FIRST` = 1);
  - a lane-merge function (old word, new word, enables → merged word).
- Sub-module `memory_rd_pipe`: a delay stage of `RD_LAT` registers carrying {valid, err, data}, reset to 0.
- The top level contains the array, the clear FSM, address checks and collision muxing.
- Parameter legality is checked at elaboration with `$error`.

## Test plan
All scenarios use the defaults except where stated.
- **Reset sweep:** assert `rst` for 2 cycles then release. `busy` is high for 6 cycles. Reading addresses 0..5 returns 0 each with `data_valid` one cycle later.
- **Basic write/read:** write `10'h123` to address 0 with `byte_en` 2'b11, then read address 0. `data_out` = `10'h123` with `data_valid` after 1 cycle.
- **Lane write:** write `10'h3FF` with `byte_en` 2'b01 over `10'h123`. A read returns `10'h13F`.
- **Collision:** write `10'h2BC` to address 1 (old value 0) while reading address 1. `RW_MODE` = 0 returns 0; `RW_MODE` = 1 returns `10'h2BC`.
- **Out of range:** write to address 7, then read address 6. Memory is unchanged. `err_flag` pulses for the write; the read gives `data_out` = 0 with `data_valid` = 1 and `err_flag` = 1.
- **`RD_LAT` = 2 with reset mid-sweep:**
  - Read address 0 (holding `10'h123`) and write `10'h000` to address 0 on the next cycle. The read still returns `10'h123` 2 cycles after the request.
  - Assert `rst` during the sweep. The sweep restarts at address 0 and `busy` is high for 6 cycles after release.

Source files
------------

// File: rtl/memory_pkg.sv
`default_nettype none
// ============================================================================
// Module   : memory_pkg
// Brief    : Shared types, collision-mode constants and lane merge helper
//            for the memory_pipe storage primitive.
// Revision : 1.0
// ============================================================================
package memory_pkg;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    localparam int RD_FIRST = 0;
    localparam int WR_FIRST = 1;

    // Widest word the merge helper handles; callers zero-extend and truncate.
    localparam int MAX_W = 64;

    function automatic logic [MAX_W-1:0] lane_merge(
        input logic [MAX_W-1:0] old_word,
        input logic [MAX_W-1:0] new_word,
        input logic [MAX_W-1:0] lane_en,
        input int               lane_w
    );
        logic [MAX_W-1:0] merged;
        merged = old_word;
        for (int b = 0; b < MAX_W; b++) begin
            if (lane_en[b / lane_w]) begin
                merged[b] = new_word[b];
            end
        end
        return merged;
    endfunction

endpackage : memory_pkg
`default_nettype wire

// File: rtl/memory_rd_pipe.sv
`default_nettype none
// ============================================================================
// Module   : memory_rd_pipe
// Brief    : Read-return delay line of RD_LAT stages carrying valid/err/data.
// Revision : 1.0
// ============================================================================
module memory_rd_pipe #(
    parameter int DATA_W = 10,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_valid,
    input  logic              i_err,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_late_err,
    output logic              o_valid,
    output logic              o_err,
    output logic [DATA_W-1:0] o_data
);

    // Write errors report one cycle after the request, so they enter the last stage.
    generate
        if (RD_LAT == 1) begin : g_lat1
            logic              r_valid;
            logic              r_err;
            logic [DATA_W-1:0] r_data;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_valid <= 1'b0;
                    r_err   <= 1'b0;
                    r_data  <= '0;
                end else begin
                    r_valid <= i_valid;
                    r_err   <= i_err | i_late_err;
                    if (i_valid) begin
                        r_data <= i_data;
                    end
                end
            end

            assign o_valid = r_valid;
            assign o_err   = r_err;
            assign o_data  = r_data;
        end else begin : g_lat2
            logic              r_valid_s1;
            logic              r_err_s1;
            logic [DATA_W-1:0] r_data_s1;
            logic              r_valid_s2;
            logic              r_err_s2;
            logic [DATA_W-1:0] r_data_s2;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_valid_s1 <= 1'b0;
                    r_err_s1   <= 1'b0;
                    r_data_s1  <= '0;
                    r_valid_s2 <= 1'b0;
                    r_err_s2   <= 1'b0;
                    r_data_s2  <= '0;
                end else begin
                    r_valid_s1 <= i_valid;
                    r_err_s1   <= i_err;
                    if (i_valid) begin
                        r_data_s1 <= i_data;
                    end
                    r_valid_s2 <= r_valid_s1;
                    r_err_s2   <= r_err_s1 | i_late_err;
                    if (r_valid_s1) begin
                        r_data_s2 <= r_data_s1;
                    end
                end
            end

            assign o_valid = r_valid_s2;
            assign o_err   = r_err_s2;
            assign o_data  = r_data_s2;
        end
    endgenerate

endmodule : memory_rd_pipe
`default_nettype wire

// File: rtl/memory_pipe.sv
`default_nettype none
// ============================================================================
// Module   : memory_pipe
// Brief    : 1W/1R memory with lane enables, selectable read latency,
//            collision mode, range checking and a reset-time clear sweep.
// Revision : 1.0
// ============================================================================
module memory_pipe
    import memory_pkg::*;
#(
    parameter int                MEM_SIZE  = 6,
    parameter int                DATA_W    = 10,
    parameter int                LANE_W    = 5,
    parameter int                RD_LAT    = 1,
    parameter int                RW_MODE   = RD_FIRST,
    parameter logic [DATA_W-1:0] INIT_VAL  = '0,
    localparam int               ADDR_SIZE = $clog2(MEM_SIZE),
    localparam int               LANES     = DATA_W / LANE_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 write_flag,
    input  logic [LANES-1:0]     byte_en,
    input  logic [DATA_W-1:0]    data_in,
    input  logic [ADDR_SIZE-1:0] addr_w,
    input  logic                 read_flag,
    input  logic [ADDR_SIZE-1:0] addr_r,
    output logic [DATA_W-1:0]    data_out,
    output logic                 data_valid,
    output logic                 err_flag,
    output logic                 busy
);

    generate
        if (MEM_SIZE < 2) begin : g_chk_size
            $error("memory_pipe: MEM_SIZE must be at least 2");
        end
        if (LANE_W < 1 || (DATA_W % LANE_W) != 0) begin : g_chk_lane
            $error("memory_pipe: DATA_W must be a positive multiple of LANE_W");
        end
        if (RD_LAT != 1 && RD_LAT != 2) begin : g_chk_lat
            $error("memory_pipe: RD_LAT must be 1 or 2");
        end
        if (RW_MODE != RD_FIRST && RW_MODE != WR_FIRST) begin : g_chk_mode
            $error("memory_pipe: RW_MODE must be 0 or 1");
        end
        if (DATA_W > MAX_W) begin : g_chk_width
            $error("memory_pipe: DATA_W exceeds lane_merge width");
        end
    endgenerate

    localparam logic [ADDR_SIZE:0]   c_mem_size = (ADDR_SIZE + 1)'(MEM_SIZE);
    localparam logic [ADDR_SIZE-1:0] c_last     = ADDR_SIZE'(MEM_SIZE - 1);

    logic [DATA_W-1:0]    r_mem [MEM_SIZE];
    state_t               r_state;
    state_t               w_state_nxt;
    logic [ADDR_SIZE-1:0] r_clr_addr;
    logic [ADDR_SIZE-1:0] w_clr_addr_nxt;
    logic                 r_busy;
    logic                 w_busy_nxt;

    logic                 w_ready;
    logic                 w_wr_in_range;
    logic                 w_rd_in_range;
    logic                 w_wr_hit;
    logic                 w_wr_err;
    logic                 w_rd_req;
    logic                 w_rd_err;
    logic [DATA_W-1:0]    w_wr_word;
    logic [DATA_W-1:0]    w_rd_word;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= CLEAR;
            r_clr_addr <= '0;
            r_busy     <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_clr_addr <= w_clr_addr_nxt;
            r_busy     <= w_busy_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_clr_addr_nxt = r_clr_addr;
        w_busy_nxt     = r_busy;
        case (r_state)
            CLEAR: begin
                w_clr_addr_nxt = r_clr_addr + ADDR_SIZE'(1);
                if (r_clr_addr == c_last) begin
                    w_state_nxt    = READY;
                    w_clr_addr_nxt = '0;
                    w_busy_nxt     = 1'b0;
                end
            end
            READY: begin
                w_busy_nxt = 1'b0;
            end
            default: begin
                w_state_nxt = CLEAR;
            end
        endcase
    end

    // Reset overrides any request presented on the same edge.
    assign w_ready       = (r_state == READY) && !rst;
    assign w_wr_in_range = {1'b0, addr_w} < c_mem_size;
    assign w_rd_in_range = {1'b0, addr_r} < c_mem_size;
    assign w_wr_hit      = w_ready && write_flag && w_wr_in_range;
    assign w_wr_err      = w_ready && write_flag && !w_wr_in_range;
    assign w_rd_req      = w_ready && read_flag;
    assign w_rd_err      = w_rd_req && !w_rd_in_range;

    assign w_wr_word = DATA_W'(lane_merge(MAX_W'(r_mem[addr_w]), MAX_W'(data_in),
                                          MAX_W'(byte_en), LANE_W));

    always_comb begin
        w_rd_word = '0;
        if (w_rd_in_range) begin
            if (RW_MODE == WR_FIRST && w_wr_hit && addr_r == addr_w) begin
                w_rd_word = w_wr_word;
            end else begin
                w_rd_word = r_mem[addr_r];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (r_state == CLEAR) begin
                r_mem[r_clr_addr] <= INIT_VAL;
            end else if (w_wr_hit) begin
                r_mem[addr_w] <= w_wr_word;
            end
        end
    end

    memory_rd_pipe #(
        .DATA_W (DATA_W),
        .RD_LAT (RD_LAT)
    ) u_rd_pipe (
        .clk        (clk),
        .rst        (rst),
        .i_valid    (w_rd_req),
        .i_err      (w_rd_err),
        .i_data     (w_rd_word),
        .i_late_err (w_wr_err),
        .o_valid    (data_valid),
        .o_err      (err_flag),
        .o_data     (data_out)
    );

    assign busy = r_busy;

endmodule : memory_pipe
`default_nettype wire

// File: tb/tb_memory_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_memory_pipe
// Brief    : Three memory_pipe configurations driven in lockstep and checked
//            against a time-indexed behavioural model.
// Revision : 1.0
// ============================================================================
module tb_memory_pipe;

    localparam int MEM_SIZE = 6;
    localparam int DATA_W   = 10;
    localparam int LANE_W   = 5;
    localparam int LANES    = 2;
    localparam int NDUT     = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             write_flag = 1'b0;
    logic [LANES-1:0] byte_en = '0;
    logic [9:0]       data_in = '0;
    logic [2:0]       addr_w = '0;
    logic             read_flag = 1'b0;
    logic [2:0]       addr_r = '0;

    logic [9:0] data_out   [NDUT];
    logic       data_valid [NDUT];
    logic       err_flag   [NDUT];
    logic       busy       [NDUT];

    always #5 clk = ~clk;

    // dut0: defaults; dut1: write-first; dut2: two-cycle latency, non-zero init
    memory_pipe #(.MEM_SIZE(6), .DATA_W(10), .LANE_W(5), .RD_LAT(1), .RW_MODE(0), .INIT_VAL(10'h000)) dut0 (
        .clk(clk), .rst(rst), .write_flag(write_flag), .byte_en(byte_en), .data_in(data_in),
        .addr_w(addr_w), .read_flag(read_flag), .addr_r(addr_r), .data_out(data_out[0]),
        .data_valid(data_valid[0]), .err_flag(err_flag[0]), .busy(busy[0]));
    memory_pipe #(.MEM_SIZE(6), .DATA_W(10), .LANE_W(5), .RD_LAT(1), .RW_MODE(1), .INIT_VAL(10'h000)) dut1 (
        .clk(clk), .rst(rst), .write_flag(write_flag), .byte_en(byte_en), .data_in(data_in),
        .addr_w(addr_w), .read_flag(read_flag), .addr_r(addr_r), .data_out(data_out[1]),
        .data_valid(data_valid[1]), .err_flag(err_flag[1]), .busy(busy[1]));
    memory_pipe #(.MEM_SIZE(6), .DATA_W(10), .LANE_W(5), .RD_LAT(2), .RW_MODE(0), .INIT_VAL(10'h155)) dut2 (
        .clk(clk), .rst(rst), .write_flag(write_flag), .byte_en(byte_en), .data_in(data_in),
        .addr_w(addr_w), .read_flag(read_flag), .addr_r(addr_r), .data_out(data_out[2]),
        .data_valid(data_valid[2]), .err_flag(err_flag[2]), .busy(busy[2]));

    int n_vec  = 0;
    int n_miss = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int lat_of(input int k);
        return (k == 2) ? 2 : 1;
    endfunction

    function automatic bit write_first(input int k);
        return k == 1;
    endfunction

    function automatic logic [9:0] init_of(input int k);
        return (k == 2) ? 10'h155 : 10'h000;
    endfunction

    function automatic logic [9:0] merge_word(input logic [9:0] old_w, input logic [9:0] new_w,
                                              input logic [LANES-1:0] be);
        logic [9:0] w;
        w = old_w;
        for (int i = 0; i < LANES; i++) begin
            if (be[i]) w[i*LANE_W +: LANE_W] = new_w[i*LANE_W +: LANE_W];
        end
        return w;
    endfunction

    // Model: memory contents plus a schedule of outputs keyed by edge number.
    logic [9:0] mdl_mem [NDUT][MEM_SIZE];
    logic       sch_v   [NDUT][4];
    logic       sch_e   [NDUT][4];
    logic [9:0] sch_d   [NDUT][4];
    logic       exp_v   [NDUT];
    logic       exp_e   [NDUT];
    logic [9:0] exp_d   [NDUT];
    logic       exp_busy = 1'b1;
    int         busy_left = 0;
    int         edge_n = 0;
    bit         started = 1'b0;

    task automatic model_step();
        int now;
        now = edge_n % 4;
        if (rst) begin
            started   = 1'b1;
            busy_left = MEM_SIZE;
            exp_busy  = 1'b1;
            for (int k = 0; k < NDUT; k++) begin
                for (int a = 0; a < MEM_SIZE; a++) mdl_mem[k][a] = init_of(k);
                for (int s = 0; s < 4; s++) begin
                    sch_v[k][s] = 1'b0;
                    sch_e[k][s] = 1'b0;
                    sch_d[k][s] = '0;
                end
                exp_v[k] = 1'b0;
                exp_e[k] = 1'b0;
                exp_d[k] = '0;
            end
        end else if (started) begin
            for (int k = 0; k < NDUT; k++) begin
                if (busy_left == 0) begin
                    if (read_flag) begin
                        int slot;
                        slot = (edge_n + lat_of(k) - 1) % 4;
                        sch_v[k][slot] = 1'b1;
                        if (addr_r >= MEM_SIZE) begin
                            sch_e[k][slot] = 1'b1;
                            sch_d[k][slot] = '0;
                        end else if (write_first(k) && write_flag && addr_w == addr_r) begin
                            sch_d[k][slot] = merge_word(mdl_mem[k][addr_r], data_in, byte_en);
                        end else begin
                            sch_d[k][slot] = mdl_mem[k][addr_r];
                        end
                    end
                    if (write_flag) begin
                        if (addr_w >= MEM_SIZE) sch_e[k][now] = 1'b1;
                        else mdl_mem[k][addr_w] = merge_word(mdl_mem[k][addr_w], data_in, byte_en);
                    end
                end
                exp_v[k] = sch_v[k][now];
                exp_e[k] = sch_e[k][now];
                if (sch_v[k][now]) exp_d[k] = sch_d[k][now];
                sch_v[k][now] = 1'b0;
                sch_e[k][now] = 1'b0;
            end
            if (busy_left > 0) busy_left--;
            exp_busy = (busy_left > 0);
        end
        edge_n++;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (started) begin
                for (int k = 0; k < NDUT; k++) begin
                    chk($sformatf("busy%0d", k),  32'(busy[k]),       32'(exp_busy));
                    chk($sformatf("valid%0d", k), 32'(data_valid[k]), 32'(exp_v[k]));
                    chk($sformatf("err%0d", k),   32'(err_flag[k]),   32'(exp_e[k]));
                    chk($sformatf("data%0d", k),  32'(data_out[k]),   32'(exp_d[k]));
                end
            end
        end
    end

    task automatic drive(input logic wf, input logic [LANES-1:0] be, input logic [9:0] din,
                         input logic [2:0] aw, input logic rf, input logic [2:0] ar);
        write_flag = wf;
        byte_en    = be;
        data_in    = din;
        addr_w     = aw;
        read_flag  = rf;
        addr_r     = ar;
        @(negedge clk);
    endtask

    task automatic idle();
        drive(1'b0, '0, '0, '0, 1'b0, '0);
    endtask

    task automatic count_busy(input string name);
        int n;
        n = 0;
        while (busy[0] && n < 20) begin
            idle();
            n++;
        end
        chk(name, 32'(n), 32'd6);
    endtask

    initial begin
        rst = 1'b1;
        @(negedge clk);
        idle();
        idle();
        rst = 1'b0;
        count_busy("busy_cycles");

        for (int a = 0; a < MEM_SIZE; a++) begin
            drive(1'b0, '0, '0, '0, 1'b1, 3'(a));
            chk($sformatf("sweep_rd%0d", a), 32'(data_out[0]), 32'h0);
            chk($sformatf("sweep_v%0d", a),  32'(data_valid[0]), 32'h1);
        end

        drive(1'b1, 2'b11, 10'h123, 3'd0, 1'b0, 3'd0);
        drive(1'b0, 2'b00, 10'h000, 3'd0, 1'b1, 3'd0);
        chk("basic_rd", 32'(data_out[0]), 32'h123);

        drive(1'b1, 2'b01, 10'h3FF, 3'd0, 1'b0, 3'd0);
        chk("model_lane", 32'(mdl_mem[0][0]), 32'h13F);
        drive(1'b0, 2'b00, 10'h000, 3'd0, 1'b1, 3'd0);
        chk("lane_rd", 32'(data_out[0]), 32'h13F);

        drive(1'b1, 2'b11, 10'h2BC, 3'd1, 1'b1, 3'd1);
        chk("coll_rdfirst", 32'(data_out[0]), 32'h000);
        chk("coll_wrfirst", 32'(data_out[1]), 32'h2BC);

        drive(1'b1, 2'b11, 10'h0AA, 3'd7, 1'b0, 3'd0);
        chk("wr_oor_err", 32'(err_flag[0]), 32'h1);
        chk("wr_oor_nov", 32'(data_valid[0]), 32'h0);
        drive(1'b0, 2'b00, 10'h000, 3'd0, 1'b1, 3'd6);
        chk("rd_oor_err",  32'(err_flag[0]), 32'h1);
        chk("rd_oor_v",    32'(data_valid[0]), 32'h1);
        chk("rd_oor_data", 32'(data_out[0]), 32'h0);

        drive(1'b1, 2'b11, 10'h123, 3'd0, 1'b0, 3'd0);
        drive(1'b0, 2'b00, 10'h000, 3'd0, 1'b1, 3'd0);
        drive(1'b1, 2'b11, 10'h000, 3'd0, 1'b0, 3'd0);
        chk("inflight_data", 32'(data_out[2]), 32'h123);
        chk("inflight_v",    32'(data_valid[2]), 32'h1);
        chk("hold_data",     32'(data_out[0]), 32'h123);

        rst = 1'b1;
        idle();
        idle();
        rst = 1'b0;
        idle();
        idle();
        idle();
        rst = 1'b1;
        idle();
        rst = 1'b0;
        count_busy("busy_restart");
        drive(1'b0, 2'b00, 10'h000, 3'd0, 1'b1, 3'd0);
        chk("restart_rd0", 32'(data_out[0]), 32'h0);

        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 10'($urandom),
                  3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
        end
        rst = 1'b0;
        for (int i = 0; i < 20 && busy[0]; i++) idle();
        for (int a = 0; a < 8; a++) drive(1'b0, '0, '0, '0, 1'b1, 3'(a));
        idle();
        idle();
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule : tb_memory_pipe
`default_nettype wire
